inc_pulse_gen: RTL and testbench

Input conditioner that produces the `inc` / `up_down_sel` drive for a counter digit from a raw push-button and a raw direction switch. It synchronizes both asynchronous inputs, debounces the button, and emits exactly one single-cycle `inc` pulse per debounced press. While the button stays held it can auto-repeat pulses. It sits between the chip input pins and the counter chain.

---
 rtl/inc_pulse_gen.sv | 166 ++++++++++++++++
 tb/tb_inc_pulse_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inc_pulse_gen.sv
// inc_pulse_gen: conditions a raw push-button and direction switch into the
// inc / up_down_sel drive of a counter digit. Both pins are synchronized,
// the button is debounced, and each accepted press yields one single-cycle
// inc pulse, optionally followed by auto-repeat pulses while it stays held.
module inc_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 4,
  parameter int unsigned TIMER_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic dir_in,
  input  logic repeat_en,
  output logic inc,
  output logic up_down_sel,
  output logic btn_state
);

  // Terminal counts: a timer reaching these on a qualifying cycle fires.
  localparam logic [TIMER_W-1:0] DB_LAST  = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RD_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] RP_LAST  = TIMER_W'(REPEAT_PERIOD - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic               btn_meta_r;
  logic               s_btn_r;
  logic               dir_meta_r;
  logic               s_dir_r;
  logic               db_r;
  logic [TIMER_W-1:0] dcnt_r;
  state_t             state_r;
  state_t             state_s;
  logic [TIMER_W-1:0] rt_r;
  logic [TIMER_W-1:0] rt_s;
  logic               pulse_s;
  logic               inc_r;
  logic               up_down_sel_r;

  // Two-flop synchronizers bring the asynchronous pins into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_r <= 1'b0;
      s_btn_r    <= 1'b0;
      dir_meta_r <= 1'b0;
      s_dir_r    <= 1'b0;
    end else begin
      btn_meta_r <= btn_in;
      s_btn_r    <= btn_meta_r;
      dir_meta_r <= dir_in;
      s_dir_r    <= dir_meta_r;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // synchronized samples disagree with the current debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r   <= 1'b0;
      dcnt_r <= {TIMER_W{1'b0}};
    end else if (s_btn_r == db_r) begin
      db_r   <= db_r;
      dcnt_r <= {TIMER_W{1'b0}};
    end else if (dcnt_r == DB_LAST) begin
      db_r   <= s_btn_r;
      dcnt_r <= {TIMER_W{1'b0}};
    end else begin
      db_r   <= db_r;
      dcnt_r <= dcnt_r + TIMER_ONE;
    end
  end

  // FSM state and repeat timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      rt_r    <= {TIMER_W{1'b0}};
    end else begin
      state_r <= state_s;
      rt_r    <= rt_s;
    end
  end

  // Next-state and pulse decision. Release is checked first, then a
  // repeat_en drop, so neither can be overridden by a timer expiry.
  always_comb begin
    state_s = state_r;
    rt_s    = rt_r;
    pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        rt_s = {TIMER_W{1'b0}};
        if (db_r) begin
          pulse_s = 1'b1;
          state_s = HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (!db_r) begin
          state_s = IDLE;
          rt_s    = {TIMER_W{1'b0}};
        end else if (!repeat_en) begin
          state_s = HOLD;
          rt_s    = {TIMER_W{1'b0}};
        end else if (rt_r == RD_LAST) begin
          pulse_s = 1'b1;
          state_s = REPEAT;
          rt_s    = {TIMER_W{1'b0}};
        end else begin
          state_s = HOLD;
          rt_s    = rt_r + TIMER_ONE;
        end
      end
      REPEAT: begin
        if (!db_r) begin
          state_s = IDLE;
          rt_s    = {TIMER_W{1'b0}};
        end else if (!repeat_en) begin
          state_s = HOLD;
          rt_s    = {TIMER_W{1'b0}};
        end else if (rt_r == RP_LAST) begin
          pulse_s = 1'b1;
          state_s = REPEAT;
          rt_s    = {TIMER_W{1'b0}};
        end else begin
          state_s = REPEAT;
          rt_s    = rt_r + TIMER_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        rt_s    = {TIMER_W{1'b0}};
      end
    endcase
  end

  // Registered outputs: inc lasts one cycle, direction is captured only
  // on a pulse edge so switch movement between pulses is never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_r         <= 1'b0;
      up_down_sel_r <= 1'b0;
    end else begin
      inc_r <= pulse_s;
      if (pulse_s) begin
        up_down_sel_r <= s_dir_r;
      end else begin
        up_down_sel_r <= up_down_sel_r;
      end
    end
  end

  assign inc         = inc_r;
  assign up_down_sel = up_down_sel_r;
  assign btn_state   = db_r;

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Self-checking bench for inc_pulse_gen: directed scenarios with arithmetic
// expectations plus a randomized run against a sample-history model.
module tb_inc_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RP = 4;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic dir_in;
  logic repeat_en;
  logic inc;
  logic up_down_sel;
  logic btn_state;

  inc_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .TIMER_W        (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .dir_in     (dir_in),
    .repeat_en  (repeat_en),
    .inc        (inc),
    .up_down_sel(up_down_sel),
    .btn_state  (btn_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int pulses[$];

  // Reference model: raw sample history plus press/interval bookkeeping.
  bit [31:0] btn_sh;
  bit [31:0] dir_sh;
  bit m_db, m_held, m_rep, m_inc, m_sel, prev_inc;
  int m_since;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_clear();
    btn_sh = '0; dir_sh = '0;
    m_db = 0; m_held = 0; m_rep = 0; m_inc = 0; m_sel = 0; prev_inc = 0; m_since = 0;
  endtask

  task automatic step();
    bit pulse, all_diff;
    @(posedge clk);
    edge_n++;
    pulse = 0;
    if (!m_held) begin
      if (m_db) begin pulse = 1; m_held = 1; m_since = 0; m_rep = 0; end
    end else if (!m_db) begin
      m_held = 0;
    end else if (!repeat_en) begin
      m_since = 0; m_rep = 0;
    end else begin
      m_since++;
      if (m_since == (m_rep ? RP : RD)) begin pulse = 1; m_since = 0; m_rep = 1; end
    end
    if (pulse) m_sel = dir_sh[1];
    // btn_sh[i] holds the pin sample taken i+1 edges ago
    all_diff = 1;
    for (int i = 1; i <= D; i++) if (btn_sh[i] == m_db) all_diff = 0;
    if (all_diff) m_db = !m_db;
    btn_sh = {btn_sh[30:0], btn_in};
    dir_sh = {dir_sh[30:0], dir_in};
    m_inc = pulse;
    #1;
    check("inc", inc, m_inc);
    check("up_down_sel", up_down_sel, m_sel);
    check("btn_state", btn_state, m_db);
    check("no_back_to_back", prev_inc && inc, 0);
    prev_inc = inc;
    if (inc === 1'b1) pulses.push_back(edge_n);
  endtask

  task automatic hold(input logic b, input int n);
    btn_in = b;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_inc", inc, 0);
    check("rst_up_down_sel", up_down_sel, 0);
    check("rst_btn_state", btn_state, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    pulses.delete();
  endtask

  initial begin
    int k, p, r, exp_n, lvl, len;
    bit found;
    btn_in = 0; dir_in = 0; repeat_en = 0; rst_n = 0;
    model_clear();
    do_reset();
    hold(0, 5);

    // Clean press, repeat disabled: one pulse, 6 edges after first high sample
    repeat_en = 0;
    pulses.delete();
    k = edge_n + 1;
    hold(1, 100);
    hold(0, 10);
    check("clean_count", pulses.size(), 1);
    if (pulses.size() > 0) check("clean_latency", pulses[0], k + 6);

    // Glitch rejection: 3 high / 1 low, five times
    pulses.delete();
    found = 0;
    for (int g = 0; g < 5; g++) begin
      btn_in = 1;
      for (int i = 0; i < 3; i++) begin step(); if (btn_state !== 1'b0) found = 1; end
      btn_in = 0;
      step(); if (btn_state !== 1'b0) found = 1;
    end
    hold(0, 8);
    check("glitch_pulses", pulses.size(), 0);
    check("glitch_btn_state", found, 0);

    // Auto-repeat: held 50 cycles after the first pulse
    repeat_en = 1;
    pulses.delete();
    k = edge_n + 1;
    hold(1, 56);
    r = edge_n + 1;
    hold(0, 12);
    p = k + 6;
    exp_n = 1;
    for (int e = p + RD; e <= r + D + 1; e += RP) exp_n++;
    check("repeat_count", pulses.size(), exp_n);
    if (pulses.size() == exp_n) begin
      check("repeat_first", pulses[0], p);
      for (int n = 1; n < exp_n; n++) check("repeat_spacing", pulses[n], p + RD + (n - 1) * RP);
    end

    // Release on expiry: debounced level falls on the edge the delay expires
    pulses.delete();
    k = edge_n + 1;
    hold(1, 16);
    hold(0, 20);
    check("expiry_count", pulses.size(), 1);
    if (pulses.size() > 0) check("expiry_first", pulses[0], k + 6);
    pulses.delete();
    k = edge_n + 1;
    hold(1, 8);
    hold(0, 10);
    check("after_expiry_press", (pulses.size() > 0) ? pulses[0] : -1, k + 6);

    // Direction latching
    repeat_en = 0;
    dir_in = 1;
    hold(0, 4);
    hold(1, 10);
    check("dir_first_pulse", up_down_sel, 1);
    dir_in = 0;
    hold(1, 30);
    check("dir_held_no_change", up_down_sel, 1);
    hold(0, 10);
    check("dir_after_release", up_down_sel, 1);
    hold(1, 10);
    check("dir_next_press", up_down_sel, 0);
    hold(0, 10);

    // Reset mid-repeat, button still held
    repeat_en = 1;
    dir_in = 1;
    pulses.delete();
    btn_in = 1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (pulses.size() >= 2 && inc === 1'b1) found = 1;
    end
    check("reset_setup_pulse", found, 1);
    do_reset();
    k = edge_n + 1;
    hold(1, 10);
    check("reset_relaunch", (pulses.size() > 0) ? pulses[0] : -1, k + 6);
    hold(0, 10);

    // Randomized bursts on all inputs
    for (int b = 0; b < 150; b++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 3) == 0) repeat_en = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0) dir_in = $urandom_range(0, 1);
      hold(lvl[0], len);
    end
    hold(0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
